// File: rtl/test_harness_ctrl_if.sv
// Run-control bus between test_harness_ctrl and its environment:
// fetch-bus snoop and dump handshake inputs, control/status outputs.
interface test_harness_ctrl_if #(
  parameter int CNT_WIDTH   = 32,
  parameter int DUMP_ADDR_W = 8
);
  logic                   ip_inst_valid;
  logic [31:0]            ip_inst_from_imem;
  logic                   ip_dump_ready;
  logic                   op_proc_reset;
  logic [CNT_WIDTH-1:0]   op_cycles;
  logic                   op_halted;
  logic                   op_dump_valid;
  logic [DUMP_ADDR_W-1:0] op_dump_addr;
  logic                   op_done;
  logic                   op_timeout;

  // Controller side
  modport master (
    input  ip_inst_valid, ip_inst_from_imem, ip_dump_ready,
    output op_proc_reset, op_cycles, op_halted, op_dump_valid,
           op_dump_addr, op_done, op_timeout
  );

  // Environment side (processor/imem snoop, dump sink)
  modport slave (
    output ip_inst_valid, ip_inst_from_imem, ip_dump_ready,
    input  op_proc_reset, op_cycles, op_halted, op_dump_valid,
           op_dump_addr, op_done, op_timeout
  );
endinterface

// File: rtl/test_harness_ctrl.sv
// Run controller for regression benches: holds the processor in reset,
// counts RUN cycles until the halt word is fetched, drains, streams dmem
// word addresses to a dump sink and guards the whole run with a watchdog.
module test_harness_ctrl #(
  parameter int          RESET_CYCLES   = 5,
  parameter int          DRAIN_CYCLES   = 5,
  parameter int          DUMP_WORDS     = 8,
  parameter int          DUMP_ADDR_W    = 8,
  parameter int          TIMEOUT_CYCLES = 100,
  parameter int          CNT_WIDTH      = 32,
  parameter logic [31:0] HALT_INST      = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  test_harness_ctrl_if.master bus
);

  // Counters only ever need to hold "cycles-1"; keep them at least 1 bit.
  localparam int HOLD_W  = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DUMP_ADDR_W-1:0] DUMP_LAST  =
    DUMP_ADDR_W'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);
  localparam logic [CNT_WIDTH-1:0]   WD_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_RUN, S_DRAIN, S_DUMP, S_DONE, S_TIMEOUT
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [DRAIN_W-1:0]     r_drain_cnt;
  logic [CNT_WIDTH-1:0]   r_wd;
  logic [CNT_WIDTH-1:0]   r_cycles;
  logic                   r_proc_reset;
  logic                   r_halted;
  logic                   r_dump_valid;
  logic [DUMP_ADDR_W-1:0] r_dump_addr;
  logic                   r_done;
  logic                   r_timeout;

  logic w_halt, w_wd_exp, w_hold_last, w_drain_last, w_dump_xfer, w_dump_last;

  assign w_halt       = bus.ip_inst_valid && (bus.ip_inst_from_imem == HALT_INST);
  // Watchdog expires on the edge that takes it to TIMEOUT_CYCLES.
  assign w_wd_exp     = (r_wd == WD_LAST);
  assign w_hold_last  = (r_hold_cnt == HOLD_LAST);
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
  assign w_dump_xfer  = r_dump_valid && bus.ip_dump_ready;
  assign w_dump_last  = w_dump_xfer && (r_dump_addr == DUMP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HOLD;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; watchdog beats halt, final dump transfer beats watchdog
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD: begin
        if (w_wd_exp)         w_state_nxt = S_TIMEOUT;
        else if (w_hold_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_wd_exp)                w_state_nxt = S_TIMEOUT;
        else if (w_halt) begin
          if (DRAIN_CYCLES > 0)      w_state_nxt = S_DRAIN;
          else if (DUMP_WORDS > 0)   w_state_nxt = S_DUMP;
          else                       w_state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        if (w_wd_exp)                w_state_nxt = S_TIMEOUT;
        else if (w_drain_last)       w_state_nxt = (DUMP_WORDS > 0) ? S_DUMP : S_DONE;
      end
      S_DUMP: begin
        if (w_dump_last)             w_state_nxt = S_DONE;
        else if (w_wd_exp)           w_state_nxt = S_TIMEOUT;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Internal counters: hold, drain and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt  <= '0;
      r_drain_cnt <= '0;
      r_wd        <= '0;
    end else begin
      if (r_state == S_HOLD && !w_hold_last) r_hold_cnt <= r_hold_cnt + 1'b1;
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                    r_drain_cnt <= '0;
      if (r_state != S_DONE && r_state != S_TIMEOUT) r_wd <= r_wd + 1'b1;
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proc_reset <= 1'b1;
      r_cycles     <= '0;
      r_halted     <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_proc_reset <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_TIMEOUT);
      if (r_state == S_RUN && !w_halt && (r_cycles != '1))
        r_cycles <= r_cycles + 1'b1;
      if (r_state == S_RUN && w_halt && !w_wd_exp)
        r_halted <= 1'b1;
      r_dump_valid <= (w_state_nxt == S_DUMP);
      if (w_state_nxt != S_DUMP) r_dump_addr <= '0;
      else if (w_dump_xfer)      r_dump_addr <= r_dump_addr + 1'b1;
      r_done       <= (w_state_nxt == S_DONE) || (w_state_nxt == S_TIMEOUT);
      r_timeout    <= (w_state_nxt == S_TIMEOUT);
    end
  end

  assign bus.op_proc_reset = r_proc_reset;
  assign bus.op_cycles     = r_cycles;
  assign bus.op_halted     = r_halted;
  assign bus.op_dump_valid = r_dump_valid;
  assign bus.op_dump_addr  = r_dump_addr;
  assign bus.op_done       = r_done;
  assign bus.op_timeout    = r_timeout;

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Bench for test_harness_ctrl: directed runs with a dump-address
// scoreboard filled at halt time and drained by a negedge monitor.
module tb_test_harness_ctrl;
  localparam logic [31:0] HALT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;

  int n_chk = 0, n_err = 0, n_xfer = 0, n_valid = 0;
  logic [31:0] sb_q[$];
  logic       stall_v = 1'b0;
  logic [7:0] stall_addr = '0;
  logic [3:0] bp_pat = 4'b1001;  // ready pattern 1,0,0,1 by index

  always #5 clk = ~clk;

  test_harness_ctrl_if #(.CNT_WIDTH(32), .DUMP_ADDR_W(8)) bus ();
  test_harness_ctrl_if #(.CNT_WIDTH(32), .DUMP_ADDR_W(8)) bus0 ();

  test_harness_ctrl u_dut (.clk(clk), .reset(rst), .bus(bus));
  test_harness_ctrl #(.DRAIN_CYCLES(0), .DUMP_WORDS(0)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int a = 0; a < 8; a++) sb_q.push_back(32'(a));
  endtask

  task automatic chk_rst();
    chk("rst_proc_reset", 32'(bus.op_proc_reset), 1);
    chk("rst_cycles",     bus.op_cycles, 0);
    chk("rst_halted",     32'(bus.op_halted), 0);
    chk("rst_dump_valid", 32'(bus.op_dump_valid), 0);
    chk("rst_dump_addr",  32'(bus.op_dump_addr), 0);
    chk("rst_done",       32'(bus.op_done), 0);
    chk("rst_timeout",    32'(bus.op_timeout), 0);
  endtask

  // Dump monitor: compare each transfer against the scoreboard and make
  // sure a stalled address is still presented on the following cycle.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v && bus.op_dump_valid)
        chk("dump_hold", 32'(bus.op_dump_addr), 32'(stall_addr));
      stall_v = 1'b0;
      if (bus.op_dump_valid) begin
        n_valid++;
        if (bus.ip_dump_ready) begin
          exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
          chk("dump_addr", 32'(bus.op_dump_addr), exp);
          n_xfer++;
        end else begin
          stall_v    = 1'b1;
          stall_addr = bus.op_dump_addr;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    bus.ip_inst_valid = 1'b0;  bus.ip_inst_from_imem = HALT; bus.ip_dump_ready = 1'b1;
    bus0.ip_inst_valid = 1'b0; bus0.ip_inst_from_imem = NOP; bus0.ip_dump_ready = 1'b0;

    // Reset sequence, halt words presented during HOLD
    tick(3);
    chk_rst();
    bus.ip_inst_valid = 1'b1; bus.ip_inst_from_imem = HALT;
    rst = 1'b0;
    tick(4);
    chk("hold_proc_reset", 32'(bus.op_proc_reset), 1);
    tick(1);
    chk("hold_exit_proc_reset", 32'(bus.op_proc_reset), 0);
    chk("hold_exit_cycles", bus.op_cycles, 0);
    chk("hold_halt_ignored", 32'(bus.op_halted), 0);
    bus.ip_inst_from_imem = NOP;

    // Normal completion: halt on RUN cycle 11, invalid halt words on 3 and 7
    for (int k = 1; k <= 10; k++) begin
      if (k == 3 || k == 7) begin
        bus.ip_inst_valid = 1'b0; bus.ip_inst_from_imem = HALT;
      end else begin
        bus.ip_inst_valid = 1'b1; bus.ip_inst_from_imem = NOP;
      end
      tick(1);
    end
    chk("run_cycles", bus.op_cycles, 10);
    chk("invalid_halt_ignored", 32'(bus.op_halted), 0);
    bus.ip_inst_valid = 1'b1; bus.ip_inst_from_imem = HALT;
    push_dump();
    tick(1);
    bus.ip_inst_from_imem = NOP;
    chk("halted", 32'(bus.op_halted), 1);
    chk("halt_cycles", bus.op_cycles, 10);
    tick(4);
    chk("drain_valid", 32'(bus.op_dump_valid), 0);
    chk("drain_cycles", bus.op_cycles, 10);
    tick(1);
    chk("dump_start_valid", 32'(bus.op_dump_valid), 1);
    chk("dump_start_addr", 32'(bus.op_dump_addr), 0);
    tick(7);
    chk("dump_last_addr", 32'(bus.op_dump_addr), 7);
    chk("dump_last_done", 32'(bus.op_done), 0);
    tick(1);
    chk("done", 32'(bus.op_done), 1);
    chk("done_valid", 32'(bus.op_dump_valid), 0);
    chk("done_addr", 32'(bus.op_dump_addr), 0);
    chk("done_timeout", 32'(bus.op_timeout), 0);
    chk("done_proc_reset", 32'(bus.op_proc_reset), 0);
    chk("sb_empty_normal", sb_q.size(), 0);
    chk("xfer_normal", n_xfer, 8);
    tick(5);
    chk("done_frozen_cycles", bus.op_cycles, 10);
    chk("done_sticky", 32'(bus.op_done), 1);

    // Dump back-pressure
    rst = 1'b1;
    tick(2);
    chk_rst();
    n_xfer = 0;
    rst = 1'b0;
    tick(7);
    push_dump();
    bus.ip_inst_from_imem = HALT;
    tick(1);
    bus.ip_inst_from_imem = NOP;
    for (int i = 0; i < 200 && !bus.op_done; i++) begin
      bus.ip_dump_ready = bp_pat[i % 4];
      tick(1);
    end
    bus.ip_dump_ready = 1'b1;
    chk("bp_done", 32'(bus.op_done), 1);
    chk("bp_timeout", 32'(bus.op_timeout), 0);
    chk("bp_xfer", n_xfer, 8);
    chk("sb_empty_bp", sb_q.size(), 0);

    // Reset pulsed during DUMP at address 3
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_xfer = 0;
    tick(7);
    push_dump();
    bus.ip_inst_from_imem = HALT;
    tick(1);
    bus.ip_inst_from_imem = NOP;
    for (int i = 0; i < 50 && !(bus.op_dump_valid && bus.op_dump_addr == 8'd3); i++) tick(1);
    chk("mr_addr", 32'(bus.op_dump_addr), 3);
    rst = 1'b1;
    tick(1);
    chk_rst();
    chk("mr_xfer", n_xfer, 3);
    sb_q.delete();
    rst = 1'b0;
    tick(4);
    chk("mr_hold", 32'(bus.op_proc_reset), 1);
    tick(1);
    chk("mr_run", 32'(bus.op_proc_reset), 0);
    chk("mr_cycles0", bus.op_cycles, 0);
    tick(3);
    chk("mr_cycles3", bus.op_cycles, 3);

    // Halt detect on the watchdog-expiry cycle
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_valid = 0;
    tick(99);
    chk("pre_exp_timeout", 32'(bus.op_timeout), 0);
    chk("pre_exp_cycles", bus.op_cycles, 94);
    bus.ip_inst_from_imem = HALT;
    tick(1);
    bus.ip_inst_from_imem = NOP;
    chk("exp_halt_timeout", 32'(bus.op_timeout), 1);
    chk("exp_halt_done", 32'(bus.op_done), 1);
    chk("exp_halt_halted", 32'(bus.op_halted), 0);
    chk("exp_halt_proc_reset", 32'(bus.op_proc_reset), 1);
    chk("exp_halt_cycles", bus.op_cycles, 94);
    tick(3);
    chk("to_held_cycles", bus.op_cycles, 94);
    chk("to_sticky", 32'(bus.op_timeout), 1);

    // Plain timeout, no halt word ever
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(99);
    chk("to_edge99", 32'(bus.op_timeout), 0);
    tick(1);
    chk("to_timeout", 32'(bus.op_timeout), 1);
    chk("to_done", 32'(bus.op_done), 1);
    chk("to_proc_reset", 32'(bus.op_proc_reset), 1);
    chk("to_cycles", bus.op_cycles, 95);
    chk("to_dump_never", n_valid, 0);

    // DRAIN_CYCLES=0, DUMP_WORDS=0: DONE right after the detect cycle
    bus0.ip_inst_valid = 1'b1;
    rst0 = 1'b0;
    tick(5);
    chk("z_proc_reset", 32'(bus0.op_proc_reset), 0);
    tick(2);
    chk("z_not_done", 32'(bus0.op_done), 0);
    bus0.ip_inst_from_imem = HALT;
    tick(1);
    bus0.ip_inst_from_imem = NOP;
    chk("z_done", 32'(bus0.op_done), 1);
    chk("z_halted", 32'(bus0.op_halted), 1);
    chk("z_valid", 32'(bus0.op_dump_valid), 0);
    chk("z_timeout", 32'(bus0.op_timeout), 0);
    chk("z_cycles", bus0.op_cycles, 2);

    chk("sb_empty_final", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/test_harness_ctrl.md
# test_harness_ctrl

Synthesisable run-control block for processor regression benches and FPGA bring-up. It sits between the `processor` and the `imem`/`dmem` pair.
- Sequences the processor reset.
- Counts execution cycles and detects the halt instruction on the fetch bus.
- Drains the pipeline, then streams a programmable number of `dmem` word addresses to a dump port.
- Enforces a cycle-accurate watchdog.

Hold, drain, dump and timeout lengths are parameters, not hard-coded delays.

## Interface
- `RESET_CYCLES`, 5: cycles `op_proc_reset` stays high after `reset` drops; ≥1.
- `DRAIN_CYCLES`, 5: cycles spent in DRAIN after halt detect; ≥0.
- `DUMP_WORDS`, 8: number of dump addresses issued; 0 skips DUMP.
- `DUMP_ADDR_W`, 8: width of `op_dump_addr`; `DUMP_WORDS` ≤ 2^`DUMP_ADDR_W`.
- `TIMEOUT_CYCLES`, 100: watchdog limit in cycles after `reset` drops; ≥2.
- `CNT_WIDTH`, 32: width of `op_cycles` and the watchdog counter.
- `HALT_INST`, 32'h0000_0000: instruction word that marks program completion.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ip_inst_valid` in 1: fetch bus valid, from `imem`.
- `ip_inst_from_imem` in 32: fetched instruction word.
- `ip_dump_ready` in 1: dump sink accepts the current address.
- `op_proc_reset` out 1: reset to `processor`, registered.
- `op_cycles` out `CNT_WIDTH`: RUN cycle count.
- `op_halted` out 1: halt instruction seen; sticky.
- `op_dump_valid` out 1: `op_dump_addr` valid.
- `op_dump_addr` out `DUMP_ADDR_W`: dmem word index to dump.
- `op_done` out 1: run finished, normally or by timeout; sticky.
- `op_timeout` out 1: watchdog expired; sticky.

## Operation
- **Reset values** while `reset`=1: `op_proc_reset`=1; all other outputs 0.
  - Also cleared: hold, drain and watchdog counters.
  - State = HOLD.
- **States:** HOLD → RUN → DRAIN → DUMP → DONE. TIMEOUT is reachable from HOLD, RUN, DRAIN and DUMP.
- **HOLD:**
  - `op_proc_reset`=1; hold counter increments each cycle.
  - Leaves on the `RESET_CYCLES`-th edge with `reset` low; `op_proc_reset`=0 from that edge.
- **RUN:**
  - `op_cycles` increments by 1 every cycle and saturates at all-ones.
  - Halt detect = `ip_inst_valid` && `ip_inst_from_imem`==`HALT_INST`.
  - On a halt-detect cycle `op_cycles` does not increment. Next state is DRAIN, or DUMP if `DRAIN_CYCLES`=0. `op_halted`=1 from the next edge.
  - Halt words in HOLD are ignored. Halt words with `ip_inst_valid`=0 are ignored.
- **DRAIN:**
  - Stays for exactly `DRAIN_CYCLES` cycles; `op_cycles` is frozen.
  - Then moves to DUMP, or to DONE if `DUMP_WORDS`=0.
- **DUMP:**
  - `op_dump_valid`=1 with `op_dump_addr` starting at 0.
  - A transfer occurs when `op_dump_valid` && `ip_dump_ready`; the address advances by 1 per transfer.
  - While `ip_dump_ready`=0 the address is held, `op_dump_valid` stays 1, and there is no skip or duplicate.
  - After the transfer at address `DUMP_WORDS`-1: move to DONE, with `op_dump_valid`=0 and `op_dump_addr` back to 0.
- **DONE:** `op_done`=1 and all counters frozen until `reset`.
- **Watchdog:**
  - Counts every cycle from the first edge with `reset` low, in all states except DONE and TIMEOUT.
  - When it reaches `TIMEOUT_CYCLES`, the next state is TIMEOUT.
- **TIMEOUT:**
  - `op_timeout`=1, `op_done`=1, `op_dump_valid`=0, `op_proc_reset`=1 (processor frozen). `op_cycles` is held.
- **Simultaneous events:**
  - Watchdog expiry with a halt detect: TIMEOUT wins.
  - Watchdog expiry with the final dump transfer: DONE wins, `op_timeout` stays 0.
- **Reset mid-run** (any state): next edge restores all reset values and state HOLD. `op_halted`, `op_done` and `op_timeout` clear.

## Timing
- All outputs registered; no combinational input→output paths.
- Halt-detect latency: `op_halted` rises 1 cycle after the detect cycle.
- `op_dump_valid` rises 1 + `DRAIN_CYCLES` cycles after the detect cycle.
- Zero-stall dump length = `DUMP_WORDS` cycles.
- `op_done` rises on the edge after the last dump transfer.
- The watchdog counts `TIMEOUT_CYCLES` edges with `reset` low; `op_timeout` is visible after that edge.

## Test plan
- **Reset sequence:** `reset` high 3 cycles then low, defaults → `op_proc_reset` high through 5 low-reset edges, 0 after the 5th; `op_cycles`=0 at that point.
- **Normal completion:** valid `HALT_INST` on RUN cycle 11, `ip_dump_ready`=1 → `op_cycles`=10 frozen; `op_halted` next cycle; 5 drain cycles; `op_dump_addr` 0..7 over 8 cycles; `op_done`=1, `op_timeout`=0.
- **Dump back-pressure:** toggle `ip_dump_ready` 1,0,0,1,... → each address 0..7 is transferred exactly once; address held while ready=0; `op_done` after transfer 7.
- **Timeout:** no halt word ever → `op_timeout`=`op_done`=1 after edge 100; `op_proc_reset`=1; `op_dump_valid` never 1.
- **Corner cases:**
  - Halt word with `ip_inst_valid`=0 → ignored.
  - Halt word during HOLD → ignored.
  - Halt detect on the watchdog-expiry cycle → TIMEOUT, `op_halted`=0.
  - `DRAIN_CYCLES`=0 with `DUMP_WORDS`=0 → DONE one cycle after the detect cycle.
- **Mid-run reset:** `reset` pulsed during DUMP at address 3 → all outputs return to reset values next edge; a full HOLD/RUN sequence restarts with `op_cycles` from 0.
